// File: rtl/alu_pkg.sv
// Shared encodings for the alu_issue stage: ALU codes, RV32I opcode/funct fields,
// FSM states and the instruction-to-ALU-code decoder.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_NOP = 3'd0,
      ALU_ADD = 3'd1,
      ALU_SUB = 3'd2,
      ALU_AND = 3'd3,
      ALU_OR  = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6
   } alu_code_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRL = 3'b101;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // ALU_NOP doubles as "not a supported instruction".
   function automatic alu_code_e decode_code(input logic [31:0] instr);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      alu_code_e  c;
      opc = instr[6:0];
      f3  = instr[14:12];
      f7  = instr[31:25];
      c   = ALU_NOP;
      if (opc == OPC_OP) begin
         case (f3)
            F3_ADD: begin
               if (f7 == F7_ZERO)     c = ALU_ADD;
               else if (f7 == F7_SUB) c = ALU_SUB;
            end
            F3_AND: c = ALU_AND;
            F3_OR:  c = ALU_OR;
            F3_SLL: if (f7 == F7_ZERO) c = ALU_SLL;
            F3_SRL: if (f7 == F7_ZERO) c = ALU_SRL;
            default: c = ALU_NOP;
         endcase
      end else if (opc == OPC_OP_IMM) begin
         case (f3)
            F3_ADD: c = ALU_ADD;
            F3_AND: c = ALU_AND;
            F3_OR:  c = ALU_OR;
            F3_SLL: if (f7 == F7_ZERO) c = ALU_SLL;
            F3_SRL: if (f7 == F7_ZERO) c = ALU_SRL;
            default: c = ALU_NOP;
         endcase
      end
      return c;
   endfunction

   function automatic logic is_shift(input alu_code_e c);
      return (c == ALU_SLL) || (c == ALU_SRL);
   endfunction

endpackage

// File: rtl/rv_regfile.sv
// Register file: two async read ports, one debug read port, one sync write port,
// x0 hardwired to zero, asynchronous active-low clear of all entries.
module rv_regfile
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      ra1_i,
   input  logic [4:0]      ra2_i,
   input  logic [4:0]      dbg_ra_i,
   output logic [XLEN-1:0] rd1_o,
   output logic [XLEN-1:0] rd2_o,
   output logic [XLEN-1:0] dbg_rd_o,
   input  logic            we_i,
   input  logic [4:0]      wa_i,
   input  logic [XLEN-1:0] wd_i
);

   logic [XLEN-1:0] mem_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      end else if (we_i && (wa_i != 5'd0)) begin
         mem_q[wa_i] <= wd_i;
      end
   end

   assign rd1_o    = (ra1_i    == 5'd0) ? '0 : mem_q[ra1_i];
   assign rd2_o    = (ra2_i    == 5'd0) ? '0 : mem_q[ra2_i];
   assign dbg_rd_o = (dbg_ra_i == 5'd0) ? '0 : mem_q[dbg_ra_i];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of the 3-bit-coded ALU (IDLE -> ISSUE -> DRAIN).
// Optional ISSUE watchdog and sticky timeout output enabled by `define ALU_TIMEOUT_EN.
module alu_issue
   import alu_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int NREGS          = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   input  logic [31:0]     instr,
   output logic            instr_ready,
   output logic [2:0]      alu_code,
   output logic [XLEN-1:0] alu_op1,
   output logic [XLEN-1:0] alu_op2,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_ready,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            illegal,
   input  logic [4:0]      dbg_raddr,
   output logic [XLEN-1:0] dbg_rdata
`ifdef ALU_TIMEOUT_EN
   ,output logic           timeout
`endif
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e          state_q, state_d;
   alu_code_e       code_q, code_d;
   logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [4:0]      rd_q, rd_d;
   logic            wb_valid_q, wb_valid_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic            illegal_q, illegal_d;
   logic            rf_we;
   logic [XLEN-1:0] rs1_data, rs2_data, dec_op2;
   alu_code_e       dec_code;

`ifdef ALU_TIMEOUT_EN
   localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;
`endif

   rv_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra1_i    (instr[19:15]),
      .ra2_i    (instr[24:20]),
      .dbg_ra_i (dbg_raddr),
      .rd1_o    (rs1_data),
      .rd2_o    (rs2_data),
      .dbg_rd_o (dbg_rdata),
      .we_i     (rf_we),
      .wa_i     (rd_q),
      .wd_i     (alu_result)
   );

   // The ALU shifts by its full op2, so shift amounts are trimmed to 5 bits here.
   always_comb begin
      dec_code = decode_code(instr);
      if (instr[6:0] == OPC_OP) begin
         dec_op2 = is_shift(dec_code) ? {{(XLEN-5){1'b0}}, rs2_data[4:0]} : rs2_data;
      end else begin
         dec_op2 = is_shift(dec_code) ? {{(XLEN-5){1'b0}}, instr[24:20]}
                                      : {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
   end

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      rd_d       = rd_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      illegal_d  = 1'b0;
      rf_we      = 1'b0;
`ifdef ALU_TIMEOUT_EN
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               if (dec_code != ALU_NOP) begin
                  code_d  = dec_code;
                  op1_d   = rs1_data;
                  op2_d   = dec_op2;
                  rd_d    = instr[11:7];
                  state_d = ISSUE;
`ifdef ALU_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (alu_ready) begin
               rf_we      = 1'b1;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = alu_result;
               code_d     = ALU_NOP;
               state_d    = DRAIN;
            end
`ifdef ALU_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
               code_d    = ALU_NOP;
               state_d   = DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DRAIN: begin
            if (!alu_ready) state_d = IDLE;
         end
         default: begin
            code_d  = ALU_NOP;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         code_q     <= ALU_NOP;
         op1_q      <= '0;
         op2_q      <= '0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         illegal_q  <= 1'b0;
`ifdef ALU_TIMEOUT_EN
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         rd_q       <= rd_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         illegal_q  <= illegal_d;
`ifdef ALU_TIMEOUT_EN
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign alu_code    = code_q;
   assign alu_op1     = op1_q;
   assign alu_op2     = op2_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign illegal     = illegal_q;
`ifdef ALU_TIMEOUT_EN
   assign timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed plan items plus randomized RV32I OP/OP-IMM traffic
// against an instruction-level reference model and a registered ALU model.
module tb_alu_issue;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            instr_valid;
   logic [31:0]     instr;
   logic            instr_ready;
   logic [2:0]      alu_code;
   logic [XLEN-1:0] alu_op1, alu_op2, alu_result;
   logic            alu_ready;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            illegal;
   logic [4:0]      dbg_raddr;
   logic [XLEN-1:0] dbg_rdata;
`ifdef ALU_TIMEOUT_EN
   logic            timeout;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit stall_en  = 1'b0;
   bit alu_block = 1'b0;
   logic [31:0] ref_rf [32];

   always #5 clk = ~clk;

   alu_issue dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .alu_code    (alu_code),
      .alu_op1     (alu_op1),
      .alu_op2     (alu_op2),
      .alu_result  (alu_result),
      .alu_ready   (alu_ready),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .illegal     (illegal),
      .dbg_raddr   (dbg_raddr),
      .dbg_rdata   (dbg_rdata)
`ifdef ALU_TIMEOUT_EN
      ,.timeout    (timeout)
`endif
   );

   // Registered ALU: result and ready one cycle after a code is applied.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_ready  <= 1'b0;
         alu_result <= '0;
      end else begin
         alu_ready <= (alu_code != 3'd0) && !alu_block && !(stall_en && ($urandom_range(0, 2) == 0));
         case (alu_code)
            3'd1: alu_result <= alu_op1 + alu_op2;
            3'd2: alu_result <= alu_op1 - alu_op2;
            3'd3: alu_result <= alu_op1 & alu_op2;
            3'd4: alu_result <= alu_op1 | alu_op2;
            3'd5: alu_result <= alu_op1 << alu_op2;
            3'd6: alu_result <= alu_op1 >> alu_op2;
            default: alu_result <= '0;
         endcase
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got hang required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction

   // Instruction-level reference: architectural effect of one instruction.
   task automatic model(input logic [31:0] ins, output bit legal, output int code,
                        output logic [31:0] op1, output logic [31:0] op2, output logic [31:0] res);
      logic [31:0] a, b, imm;
      logic [6:0]  f7;
      a     = ref_rf[ins[19:15]];
      b     = ref_rf[ins[24:20]];
      imm   = {{20{ins[31]}}, ins[31:20]};
      f7    = ins[31:25];
      legal = 1'b0; code = 0; op1 = a; op2 = '0; res = '0;
      if (ins[6:0] == 7'h33) begin
         case (ins[14:12])
            3'd0: if (f7 == 7'h00) begin legal = 1; code = 1; op2 = b; res = a + b; end
                  else if (f7 == 7'h20) begin legal = 1; code = 2; op2 = b; res = a - b; end
            3'd7: begin legal = 1; code = 3; op2 = b; res = a & b; end
            3'd6: begin legal = 1; code = 4; op2 = b; res = a | b; end
            3'd1: if (f7 == 7'h00) begin legal = 1; code = 5; op2 = b % 32; res = a << op2; end
            3'd5: if (f7 == 7'h00) begin legal = 1; code = 6; op2 = b % 32; res = a >> op2; end
            default: ;
         endcase
      end else if (ins[6:0] == 7'h13) begin
         case (ins[14:12])
            3'd0: begin legal = 1; code = 1; op2 = imm; res = a + imm; end
            3'd7: begin legal = 1; code = 3; op2 = imm; res = a & imm; end
            3'd6: begin legal = 1; code = 4; op2 = imm; res = a | imm; end
            3'd1: if (f7 == 7'h00) begin legal = 1; code = 5; op2 = {27'd0, ins[24:20]}; res = a << op2; end
            3'd5: if (f7 == 7'h00) begin legal = 1; code = 6; op2 = {27'd0, ins[24:20]}; res = a >> op2; end
            default: ;
         endcase
      end
   endtask

   function automatic logic [31:0] gen_instr();
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] imm;
      logic [31:0] w;
      rd  = 5'($urandom_range(0, 15));
      rs1 = 5'($urandom_range(0, 15));
      rs2 = 5'($urandom_range(0, 15));
      imm = 12'($urandom);
      case ($urandom_range(0, 14))
         0:  return enc_r(7'h00, rs2, rs1, 3'd0, rd);
         1:  return enc_r(7'h20, rs2, rs1, 3'd0, rd);
         2:  return enc_r(7'h00, rs2, rs1, 3'd7, rd);
         3:  return enc_r(7'h00, rs2, rs1, 3'd6, rd);
         4:  return enc_r(7'h00, rs2, rs1, 3'd1, rd);
         5:  return enc_r(7'h00, rs2, rs1, 3'd5, rd);
         6:  return enc_i(imm, rs1, 3'd0, rd);
         7:  return enc_i(imm, rs1, 3'd7, rd);
         8:  return enc_i(imm, rs1, 3'd6, rd);
         9:  return enc_i({7'h00, imm[4:0]}, rs1, 3'd1, rd);
         10: return enc_i({7'h00, imm[4:0]}, rs1, 3'd5, rd);
         11: return enc_i({7'h20, imm[4:0]}, rs1, 3'd5, rd);
         12: return enc_r(7'h00, rs2, rs1, 3'($urandom_range(2, 4)), rd);
         13: return enc_r(7'h01, rs2, rs1, 3'd0, rd);
         default: begin
            w = $urandom;
            if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[6:0] = 7'h03;
            return w;
         end
      endcase
   endfunction

   // Issue one instruction; timed=1 also checks the nominal cycle-by-cycle schedule.
   task automatic run_instr(input logic [31:0] ins, input bit timed);
      bit          legal, seen;
      int          code, k;
      logic [31:0] op1, op2, res, old;
      logic [4:0]  rd;
      rd = ins[11:7];
      model(ins, legal, code, op1, op2, res);
      old = ref_rf[rd];
      @(negedge clk);
      k = 0;
      while (!instr_ready && k < 50) begin @(negedge clk); k++; end
      if (!instr_ready) chk("accept_wait", 32'(instr_ready), 32'd1);
      dbg_raddr = rd; instr = ins; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0; instr = $urandom;
      @(negedge clk); k = 1;
      if (!legal) begin
         chk("illegal_pulse", 32'(illegal), 32'd1);
         chk("illegal_code", 32'(alu_code), 32'd0);
         chk("illegal_ready", 32'(instr_ready), 32'd1);
         @(negedge clk);
         chk("illegal_clear", 32'(illegal), 32'd0);
         chk("illegal_noreg", dbg_rdata, old);
         return;
      end
      chk("code", 32'(alu_code), 32'(code));
      chk("op1", alu_op1, op1);
      chk("op2", alu_op2, op2);
      chk("busy_ready", 32'(instr_ready), 32'd0);
      seen = 1'b0;
      while (k < 60 && !seen) begin
         if (wb_valid) begin
            seen = 1'b1;
         end else begin
            if (timed && k == 2) chk("dbg_old", dbg_rdata, old);
            @(negedge clk); k++;
         end
      end
      if (!seen) begin
         chk("wb_seen", 32'd0, 32'd1);
      end else begin
         if (timed) chk("wb_cycle", 32'(k), 32'd3);
         chk("wb_rd", 32'(wb_rd), 32'(rd));
         chk("wb_data", wb_data, res);
         chk("dbg_new", dbg_rdata, (rd == 5'd0) ? 32'd0 : res);
      end
      if (rd != 5'd0) ref_rf[rd] = res;
      @(negedge clk); k++;
      chk("wb_one_cycle", 32'(wb_valid), 32'd0);
      while (!instr_ready && k < 90) begin @(negedge clk); k++; end
      if (timed) chk("ready_cycle", 32'(k), 32'd5);
      else       chk("ready_back", 32'(instr_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_code"}, 32'(alu_code), 32'd0);
      chk({tag, "_op1"}, alu_op1, 32'd0);
      chk({tag, "_op2"}, alu_op2, 32'd0);
      chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
      chk({tag, "_wbrd"}, 32'(wb_rd), 32'd0);
      chk({tag, "_wbdata"}, wb_data, 32'd0);
      chk({tag, "_illegal"}, 32'(illegal), 32'd0);
      chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
`ifdef ALU_TIMEOUT_EN
      chk({tag, "_timeout"}, 32'(timeout), 32'd0);
`endif
   endtask

   initial begin
      rst_n = 1'b0; instr_valid = 1'b0; instr = '0; dbg_raddr = '0;
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      run_instr(32'h00500093, 1'b1);                       // ADDI x1,x0,5
      run_instr(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), 1'b1);   // ADDI x2,x0,-3
      run_instr(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1); // SUB x3,x1,x2
      run_instr(enc_i(12'd3, 5'd1, 3'd1, 5'd4), 1'b1);     // SLLI x4,x1,3
      run_instr(enc_i(12'h021, 5'd0, 3'd0, 5'd6), 1'b1);   // ADDI x6,x0,0x21
      run_instr(enc_r(7'h00, 5'd6, 5'd1, 3'd1, 5'd7), 1'b1); // SLL x7,x1,x6
      run_instr(enc_i(12'd7, 5'd0, 3'd0, 5'd0), 1'b1);     // ADDI x0,x0,7
      run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 1'b1);
      run_instr(enc_i(12'h403, 5'd1, 3'd5, 5'd8), 1'b1);   // SRAI-style, rejected

      dbg_raddr = 5'd3; #1 chk("x3_sub", dbg_rdata, 32'd8);
      dbg_raddr = 5'd4; #1 chk("x4_slli", dbg_rdata, 32'd40);
      dbg_raddr = 5'd7; #1 chk("x7_sll_masked", dbg_rdata, 32'd10);
      dbg_raddr = 5'd0; #1 chk("x0_zero", dbg_rdata, 32'd0);
      dbg_raddr = 5'd2; #1 chk("x2_neg", dbg_rdata, 32'hFFFF_FFFD);

      // Reset in the middle of ISSUE of ADDI x5,x0,9.
      @(negedge clk);
      dbg_raddr = 5'd5; instr = enc_i(12'd9, 5'd0, 3'd0, 5'd5); instr_valid = 1'b1;
      @(posedge clk); #1 instr_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_code", 32'(alu_code), 32'd1);
      rst_n = 1'b0; #1;
      check_reset_outputs("midreset");
      chk("midreset_x5", dbg_rdata, 32'd0);
      dbg_raddr = 5'd1; #1 chk("midreset_x1_clear", dbg_rdata, 32'd0);
      for (int i = 0; i < 32; i++) ref_rf[i] = '0;
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      dbg_raddr = 5'd5; #1 chk("after_reset_x5", dbg_rdata, 32'd0);

      stall_en = 1'b1;
      repeat (120) run_instr(gen_instr(), 1'b0);
      stall_en = 1'b0;
      for (int r = 0; r < 32; r++) begin
         dbg_raddr = 5'(r); #1;
         chk($sformatf("final_x%0d", r), dbg_rdata, ref_rf[r]);
      end

`ifdef ALU_TIMEOUT_EN
      begin
         int k;
         bit wb_seen;
         alu_block = 1'b1;
         @(negedge clk);
         dbg_raddr = 5'd9; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd9); instr_valid = 1'b1;
         @(posedge clk); #1 instr_valid = 1'b0;
         k = 0; wb_seen = 1'b0;
         do begin
            @(negedge clk); k++;
            if (wb_valid) wb_seen = 1'b1;
         end while (!timeout && k < 40);
         chk("timeout_cycle", 32'(k), 32'd17);
         chk("timeout_no_wb", 32'(wb_seen), 32'd0);
         @(negedge clk);
         chk("timeout_idle", 32'(instr_ready), 32'd1);
         chk("timeout_no_write", dbg_rdata, ref_rf[9]);
         alu_block = 1'b0;
         run_instr(32'h00500093, 1'b1);
         chk("timeout_sticky", 32'(timeout), 32'd1);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue/writeback stage directly upstream of the 3-bit-coded ALU.
- Accepts RV32I OP/OP-IMM instructions over a valid/ready handshake and reads operands from an internal 32x32 register file.
- Drives alu_code/op1/op2, waits for the ALU's registered ready, writes the result back to rd, then drains the ALU to NOP.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register count; x0 hardwired to zero.
- TIMEOUT_CYCLES, 16, ISSUE-state watchdog limit; used only with ALU_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  32  RV32I instruction word.
- instr_ready  out  1  stage can accept (IDLE only).
- alu_code  out  3  to ALU; NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLL=5, SRL=6.
- alu_op1  out  XLEN  to ALU.
- alu_op2  out  XLEN  to ALU.
- alu_result  in  XLEN  from ALU.
- alu_ready  in  1  from ALU; registered, high while a non-NOP code is applied.
- wb_valid  out  1  one-cycle pulse on register write.
- wb_rd  out  5  written register index.
- wb_data  out  XLEN  written value.
- illegal  out  1  one-cycle pulse: rejected instruction.
- dbg_raddr  in  5  debug read address.
- dbg_rdata  out  XLEN  combinational regfile read; x0 reads 0.
- timeout  out  1  sticky watchdog flag; present only with ALU_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - FSM returns to IDLE; all registers x1..x31 cleared to 0.
  - alu_code=NOP; alu_op1=alu_op2=0.
  - wb_valid=0, wb_rd=0, wb_data=0, illegal=0, timeout=0.
  - Reset mid-operation aborts the instruction; no write occurs.
- Decode, OP (opcode 0110011):
  - funct3 000 with funct7 0000000 -> ADD; funct7 0100000 -> SUB.
  - 111 -> AND; 110 -> OR.
  - 001 -> SLL and 101 -> SRL, funct7 0000000 only.
- Decode, OP-IMM (opcode 0010011):
  - 000 ADDI, 111 ANDI, 110 ORI: op2 = sign-extended imm[11:0].
  - 001 SLLI and 101 SRLI: require imm[11:5]=0.
- Shift operands: op2 for SLL/SRL/SLLI/SRLI is masked to bits [4:0], zero-extended, because the ALU shifts by the full op2.
- Illegal instructions: any other encoding is accepted with no state change. illegal pulses the cycle after acceptance; the FSM stays in IDLE.
- State IDLE:
  - instr_ready=1; alu_code=NOP.
  - On instr_valid: decode, read rs1/rs2 (x0 = 0), latch code, operands and rd. Go to ISSUE.
- State ISSUE:
  - alu_code, alu_op1 and alu_op2 are held at the latched values.
  - On alu_ready=1: capture alu_result, write rd (suppressed if rd=0), pulse wb_valid/wb_rd/wb_data, go to DRAIN.
- State DRAIN:
  - alu_code=NOP; stay until alu_ready=0, then go to IDLE.
- Nominal timing:
  - Accept at cycle 0.
  - ALU computes at the end of cycle 1; alu_ready=1 in cycle 2.
  - Writeback at the end of cycle 2; wb_valid=1 in cycle 3.
  - Drain completes in cycle 4; instr_ready=1 again in cycle 5.
- Hazards: none, because reads happen only in IDLE, after the prior write.
- Simultaneous events: the debug read sees the old value in the same cycle as a write; the new value is visible the following cycle.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined: a counter runs in ISSUE. If alu_ready is not seen within TIMEOUT_CYCLES cycles:
  - timeout sets (sticky until reset);
  - no write occurs;
  - the FSM goes to DRAIN.
- Undefined: no counter and no timeout port; ISSUE waits indefinitely.

Decomposition:
- Package alu_pkg:
  - ALU code constants NOP/ADD/SUB/AND/OR/SLL/SRL;
  - opcode constants OP/OP_IMM;
  - funct3/funct7 constants;
  - FSM state enum IDLE/ISSUE/DRAIN.
- Sub-module rv_regfile:
  - two async read ports plus debug read;
  - one sync write port;
  - x0 forced to zero;
  - asynchronous active-low clear.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093) -> alu_code=1, op1=0, op2=5; wb_valid with rd=1, data=5 at cycle 3; dbg x1=5.
- ADDI x2,x0,-3, then SUB x3,x1,x2 -> op2=0xFFFFFFFD; x3=8; instr_ready low for cycles 1-4 of each instruction.
- SLLI x4,x1,3 -> op2=3, x4=40. Then SLL with rs2 holding 0x00000021 -> op2 masked to 1.
- ADDI x0,x0,7 -> ALU cycle occurs, no write; x0 reads 0. Then opcode 0x33 with funct3=010 -> illegal pulse, no alu_code change.
- Assert rst_n low during ISSUE of ADDI x5,x0,9 -> outputs return to reset values immediately; x5 stays 0.
- With ALU_TIMEOUT_EN and alu_ready tied 0, ADD issued -> timeout=1 after 16 ISSUE cycles, no wb_valid, FSM back to IDLE.
